// File: rtl/frame_max_tracker_pkg.sv
// frame_max_pkg: shared state encoding, default sizes and index-width helper.
package frame_max_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
    localparam int WIDTH_DEF = 8;
    localparam int FRAME_LEN_DEF = 16;
    function automatic int idx_w(input int frame_len);
        return frame_len > 1 ? $clog2(frame_len) : 1;
    endfunction
endpackage

// File: rtl/frame_max_tracker_if.sv
// frame_max_tracker_if: sample stream, result handshake and status of frame_max_tracker.
// Min result signals exist only when FRAME_MAX_TRACKER_MIN_EN is defined.
interface frame_max_tracker_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
);
    logic start;
    logic in_valid;
    logic [WIDTH-1:0] in_data;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic [WIDTH-1:0] max_val;
    logic [IDX_W-1:0] max_idx;
    logic busy;
`ifdef FRAME_MAX_TRACKER_MIN_EN
    logic [WIDTH-1:0] min_val;
    logic [IDX_W-1:0] min_idx;
    modport master (
        output start, in_valid, in_data, out_ready,
        input in_ready, out_valid, max_val, max_idx, busy, min_val, min_idx
    );
    modport slave (
        input start, in_valid, in_data, out_ready,
        output in_ready, out_valid, max_val, max_idx, busy, min_val, min_idx
    );
`else
    modport master (
        output start, in_valid, in_data, out_ready,
        input in_ready, out_valid, max_val, max_idx, busy
    );
    modport slave (
        input start, in_valid, in_data, out_ready,
        output in_ready, out_valid, max_val, max_idx, busy
    );
`endif
endinterface

// File: rtl/frame_max_tracker_mag_gt.sv
// mag_gt: combinational unsigned greater-than, gt = a > b.
module mag_gt #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt
);
    assign gt = a > b;
endmodule

// File: rtl/frame_max_tracker.sv
// frame_max_tracker: max (first index) over a FRAME_LEN-sample frame, result on a valid/ready handshake.
// Defining FRAME_MAX_TRACKER_MIN_EN also tracks the minimum and its first index.
module frame_max_tracker
    import frame_max_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input logic clk,
    input logic rst_n,
    frame_max_tracker_if.slave bus
);
    localparam int IDX_W = idx_w(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
    state_e state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d, max_idx_q, max_idx_d;
    logic [WIDTH-1:0] max_val_q, max_val_d;
    logic accept, first, last, gt_max;
    mag_gt #(.WIDTH(WIDTH)) u_gt_max (.a(bus.in_data), .b(max_val_q), .gt(gt_max));
    assign accept = state_q == ACCUM && bus.in_valid;
    assign first = count_q == '0;
    assign last = count_q == LAST;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (state_q == IDLE && bus.start) begin
            state_d = ACCUM;
            count_d = '0;
        end
        if (accept) begin
            state_d = last ? DONE : ACCUM;
            count_d = last ? count_q : count_q + 1'b1;
        end
        // Strict compare keeps the earliest index on ties
        if (accept && (first || gt_max)) begin
            max_val_d = bus.in_data;
            max_idx_d = count_q;
        end
        if (state_q == DONE && bus.out_ready) state_d = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end
    assign bus.in_ready = state_q == ACCUM;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy = state_q != IDLE;
    assign bus.max_val = max_val_q;
    assign bus.max_idx = max_idx_q;
`ifdef FRAME_MAX_TRACKER_MIN_EN
    logic [WIDTH-1:0] min_val_q, min_val_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic gt_min;
    mag_gt #(.WIDTH(WIDTH)) u_gt_min (.a(min_val_q), .b(bus.in_data), .gt(gt_min));
    always_comb begin
        min_val_d = min_val_q;
        min_idx_d = min_idx_q;
        if (accept && (first || gt_min)) begin
            min_val_d = bus.in_data;
            min_idx_d = count_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_val_q <= '0;
            min_idx_q <= '0;
        end else begin
            min_val_q <= min_val_d;
            min_idx_q <= min_idx_d;
        end
    end
    assign bus.min_val = min_val_q;
    assign bus.min_idx = min_idx_q;
`endif
endmodule

// File: tb/tb_frame_max_tracker.sv
// tb_frame_max_tracker: randomized frames for FRAME_LEN=4 and FRAME_LEN=1 against a queue-based reference.
// Min checks are enabled with FRAME_MAX_TRACKER_MIN_EN.
module tb_frame_max_tracker;
    import frame_max_pkg::*;
    localparam int W = 8;
    localparam int N = 4;
    localparam int IW = idx_w(N);
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    int q[$];
    always #5 clk = ~clk;
    frame_max_tracker_if #(.WIDTH(W), .IDX_W(IW)) b4 ();
    frame_max_tracker_if #(.WIDTH(W), .IDX_W(1)) b1 ();
    frame_max_tracker #(.WIDTH(W), .FRAME_LEN(N)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    frame_max_tracker #(.WIDTH(W), .FRAME_LEN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    function automatic int ref_max(input int s[$]);
        int m = 0;
        for (int i = 0; i < s.size(); i++) if (s[i] > m) m = s[i];
        return m;
    endfunction
    function automatic int ref_min(input int s[$]);
        int m = 255;
        for (int i = 0; i < s.size(); i++) if (s[i] < m) m = s[i];
        return m;
    endfunction
    function automatic int first_idx(input int s[$], input int v);
        int r = -1;
        for (int i = 0; i < s.size(); i++) if (r < 0 && s[i] == v) r = i;
        return r;
    endfunction
    task automatic run4(input int s[$], input int hold, input string tag);
        int i = 0;
        int cyc = 0;
        int em, ei;
        logic acc;
        logic [W-1:0] held_val;
        logic [IW-1:0] held_idx;
        em = ref_max(s);
        ei = first_idx(s, em);
        @(negedge clk);
        b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        chk({tag, ".busy_accum"}, b4.busy, 1);
        while (i < N && cyc < 60) begin
            b4.in_valid = $urandom_range(0, 2) != 0;
            b4.in_data = b4.in_valid ? W'(s[i]) : W'($urandom_range(0, 255));
            b4.start = $urandom_range(0, 7) == 0;
            acc = b4.in_valid && b4.in_ready;
            @(negedge clk);
            cyc++;
            if (acc) i++;
            if (i < N) chk({tag, ".no_early_valid"}, b4.out_valid, 0);
        end
        if (i < N) chk({tag, ".accept_timeout"}, 0, 1);
        b4.start = 1'b0;
        b4.in_valid = 1'b1;
        b4.in_data = W'($urandom_range(0, 255));
        chk({tag, ".out_valid"}, b4.out_valid, 1);
        chk({tag, ".in_ready_done"}, b4.in_ready, 0);
        chk({tag, ".max_val"}, b4.max_val, em);
        chk({tag, ".max_idx"}, b4.max_idx, ei);
`ifdef FRAME_MAX_TRACKER_MIN_EN
        chk({tag, ".min_val"}, b4.min_val, ref_min(s));
        chk({tag, ".min_idx"}, b4.min_idx, first_idx(s, ref_min(s)));
`endif
        held_val = b4.max_val;
        held_idx = b4.max_idx;
        for (int k = 0; k < hold; k++) begin
            b4.start = $urandom_range(0, 1) != 0;
            b4.in_data = W'($urandom_range(0, 255));
            @(negedge clk);
            chk({tag, ".hold_valid"}, b4.out_valid, 1);
            chk({tag, ".hold_max"}, {b4.max_val, b4.max_idx}, {held_val, held_idx});
        end
        b4.out_ready = 1'b1;
        b4.start = 1'b1;
        @(negedge clk);
        b4.out_ready = 1'b0;
        b4.start = 1'b0;
        b4.in_valid = 1'b0;
        chk({tag, ".idle_valid"}, b4.out_valid, 0);
        chk({tag, ".idle_busy"}, b4.busy, 0);
    endtask
    initial begin
        b4.start = 0; b4.in_valid = 0; b4.in_data = 0; b4.out_ready = 0;
        b1.start = 0; b1.in_valid = 0; b1.in_data = 0; b1.out_ready = 0;
        #12;
        chk("rst.in_ready", b4.in_ready, 0);
        chk("rst.out_valid", b4.out_valid, 0);
        chk("rst.busy", b4.busy, 0);
        chk("rst.max", {b4.max_val, b4.max_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q = {3, 9, 2, 7};       run4(q, 0, "basic");
        q = {5, 8, 8, 1};       run4(q, 2, "ties");
        q = {255, 0, 255, 128}; run4(q, 1, "bounds");
        q = {0, 0, 0, 0};       run4(q, 0, "zeros");
        q = {10, 20, 30, 40};   run4(q, 5, "backpressure");
        @(negedge clk);
        b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        b4.in_valid = 1'b1;
        b4.in_data = 8'd200;
        @(negedge clk);
        b4.in_data = 8'd100;
        @(negedge clk);
        b4.in_valid = 1'b0;
        chk("pre_rst.max", b4.max_val, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.max", {b4.max_val, b4.max_idx}, 0);
        chk("async_rst.status", {b4.busy, b4.in_ready, b4.out_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q = {1, 2, 3, 4}; run4(q, 0, "after_rst");
        for (int f = 0; f < 20; f++) begin
            int hi;
            hi = (f % 2 == 0) ? 3 : 255;
            q.delete();
            for (int j = 0; j < N; j++) q.push_back($urandom_range(0, hi));
            run4(q, $urandom_range(0, 4), "rnd");
        end
        @(negedge clk);
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        b1.in_valid = 1'b1;
        b1.in_data = 8'h42;
        @(negedge clk);
        b1.in_valid = 1'b0;
        chk("len1.out_valid", b1.out_valid, 1);
        chk("len1.max_val", b1.max_val, 8'h42);
        chk("len1.max_idx", b1.max_idx, 0);
        chk("len1.in_ready", b1.in_ready, 0);
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
        chk("len1.idle_busy", b1.busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
